// File: rtl/huff_pkg.sv
// Shared types for the Huffman encoder byte path.
// The byte record is reused by the encoder-side bench.
package huff_pkg;

  localparam int BYTE_W  = 8;
  localparam int NBITS_W = 4;

  typedef struct packed {
    logic [BYTE_W-1:0]  data;
    logic               last;
    logic [NBITS_W-1:0] nbits;
  } huff_byte_t;

endpackage

// File: rtl/huff_byte_fifo.sv
// First-word-fall-through byte FIFO.
// Pointers carry one wrap bit beyond the index.
module huff_byte_fifo
  import huff_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  huff_byte_t i_wdata,
  input  logic       i_pop,
  output huff_byte_t o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  huff_byte_t  r_mem [FIFO_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_wen;
  logic w_ren;

  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_empty = (r_wr == r_rd);

  // A pop frees the head slot on the same edge, so a full push is legal
  assign w_wen = i_push && (!w_full || i_pop);
  assign w_ren = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wen) r_wr <= r_wr + 1'b1;
      if (w_ren) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/huff_bit_packer.sv
// Packs the encoder's serial code bursts into MSB-first bytes
// with last/nbits framing, buffered behind a valid/ready port.
module huff_bit_packer
  import huff_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [3:0] out_nbits,
  output logic       overflow
);

  logic [7:0] r_sreg;
  logic [2:0] r_cnt;
  logic [7:0] r_stg;
  logic       r_stg_full;
  logic       r_prev_valid;
  logic       r_overflow;

  logic       w_flush;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [3:0] w_sh;
  logic [7:0] w_tail;
  huff_byte_t w_wdata;
  huff_byte_t w_rdata;

  assign w_flush = r_prev_valid && !in_valid && (r_cnt != 3'd0);
  assign w_push  = r_stg_full || w_flush;
  assign w_pop   = !w_empty && out_ready;

  // Left-justify the partial byte so unused low bits read as zero
  assign w_sh   = 4'd8 - {1'b0, r_cnt};
  assign w_tail = r_sreg << w_sh;

  always_comb begin
    w_wdata = '0;
    if (r_stg_full) begin
      w_wdata.data  = r_stg;
      w_wdata.last  = !in_valid;
      w_wdata.nbits = 4'd8;
    end else if (w_flush) begin
      w_wdata.data  = w_tail;
      w_wdata.last  = 1'b1;
      w_wdata.nbits = {1'b0, r_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_stg        <= '0;
      r_stg_full   <= 1'b0;
      r_prev_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_valid <= in_valid;
      r_stg_full   <= in_valid && (r_cnt == 3'd7);
      if (in_valid) begin
        r_sreg <= {r_sreg[6:0], in_code};
        r_cnt  <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) r_stg <= {r_sreg[6:0], in_code};
      end else if (w_flush) begin
        r_sreg <= '0;
        r_cnt  <= '0;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  huff_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_wdata(w_wdata),
    .i_pop  (w_pop),
    .o_rdata(w_rdata),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = out_valid ? w_rdata.data  : 8'd0;
  assign out_last  = out_valid ? w_rdata.last  : 1'b0;
  assign out_nbits = out_valid ? w_rdata.nbits : 4'd0;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_huff_bit_packer.sv
// Self-checking bench for huff_bit_packer: directed table,
// hand-written corner sequences and a randomized scoreboard.
module tb_huff_bit_packer;
  import huff_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] out_nbits;
  logic       overflow;

  huff_bit_packer #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_nbits(out_nbits),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] code;
    int          nbytes;
    logic [7:0]  first;
    logic [7:0]  lastb;
    int          lastn;
  } vec_t;

  vec_t       vt [7];
  huff_byte_t got [$];
  huff_byte_t exp_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         rmode  = 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic huff_byte_t at(input int i);
    if (i >= 0 && i < got.size()) return got[i];
    return '0;
  endfunction

  task automatic step(input logic v, input logic c);
    in_valid  = v;
    in_code   = c;
    out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
    if (!rst && out_valid && out_ready)
      got.push_back(huff_byte_t'{out_data, out_last, out_nbits});
    if (!rst && !out_valid)
      chk("idle_zero", {19'd0, out_data, out_last, out_nbits}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input logic [31:0] code);
    for (int i = len - 1; i >= 0; i--) step(1'b1, code[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    got.delete();
  endtask

  // Reference: left-justify the code, cut it into bytes
  task automatic model(input int len, input logic [31:0] code);
    logic [31:0] lj;
    int          nb;
    huff_byte_t  b;
    lj = code << (32 - len);
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b.data  = lj[31-8*k -: 8];
      b.last  = (k == nb - 1);
      b.nbits = b.last ? 4'(len - 8 * (nb - 1)) : 4'd8;
      exp_q.push_back(b);
    end
  endtask

  task automatic chk_seq(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({name, "_byte"}, {19'd0, at(i)}, {19'd0, exp_q[i]});
  endtask

  initial begin
    vt[0] = '{5,  32'h16,       1, 8'hB0, 8'hB0, 5};
    vt[1] = '{16, 32'hA5C3,     2, 8'hA5, 8'hC3, 8};
    vt[2] = '{1,  32'h1,        1, 8'h80, 8'h80, 1};
    vt[3] = '{8,  32'h3C,       1, 8'h3C, 8'h3C, 8};
    vt[4] = '{9,  32'h101,      2, 8'h80, 8'h80, 1};
    vt[5] = '{31, 32'h7FFFFFFF, 4, 8'hFF, 8'hFE, 7};
    vt[6] = '{12, 32'hABC,      2, 8'hAB, 8'hC0, 4};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 1'b0;
    out_ready = 1'b0;
    rmode     = 0;
    do_reset();

    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_last",  out_last,  0);
    chk("rst_nbits", out_nbits, 0);
    chk("rst_ovf",   overflow,  0);

    // Table of single bursts, sink always ready
    rmode = 1;
    foreach (vt[v]) begin
      do_reset();
      send(vt[v].len, vt[v].code);
      idle(20);
      chk("tbl_count", got.size(), vt[v].nbytes);
      chk("tbl_first", at(0).data, vt[v].first);
      chk("tbl_first_last", at(0).last, vt[v].nbytes == 1);
      chk("tbl_lastb", at(vt[v].nbytes - 1).data, vt[v].lastb);
      chk("tbl_lastflag", at(vt[v].nbytes - 1).last, 1);
      chk("tbl_lastn", at(vt[v].nbytes - 1).nbits, vt[v].lastn);
      chk("tbl_ovf", overflow, 0);
    end

    // Final-byte latency: valid rises one edge after the idle edge
    do_reset();
    rmode = 1;
    send(5, 32'h16);
    chk("lat_pre", out_valid, 0);
    step(1'b0, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_data",  out_data,  8'hB0);
    chk("lat_last",  out_last,  1);
    chk("lat_nbits", out_nbits, 5);

    // 31 bits held with sink stalled, then drained
    do_reset();
    rmode = 0;
    send(31, 32'h12345678);
    idle(3);
    chk("hold_valid", out_valid, 1);
    chk("hold_ovf",   overflow,  0);
    chk("hold_head",  out_data,  8'h24);
    rmode = 1;
    idle(10);
    exp_q.delete();
    model(31, 32'h12345678);
    chk_seq("hold");

    // Second burst overflows the full FIFO
    do_reset();
    rmode = 0;
    send(31, 32'h12345678);
    idle(1);
    send(31, 32'h7FFFFFFF);
    idle(2);
    chk("ovf_set",  overflow, 1);
    chk("ovf_head", out_data, 8'h24);
    rmode = 1;
    idle(10);
    chk_seq("ovf");
    chk("ovf_sticky", overflow, 1);

    // Push and pop on the same edge while full
    do_reset();
    rmode = 0;
    send(31, 32'h12345678);
    idle(2);
    send(8, 32'hB2);
    rmode = 1;
    step(1'b0, 1'b0);
    chk("pp_ovf", overflow, 0);
    idle(10);
    model(8, 32'hB2);
    chk_seq("pp");
    chk("pp_ovf_end", overflow, 0);

    // Reset in the middle of a burst
    do_reset();
    rmode = 0;
    send(5, 32'h16);
    idle(1);
    send(3, 32'h7);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data",  out_data,  0);
    chk("mrst_last",  out_last,  0);
    chk("mrst_nbits", out_nbits, 0);
    chk("mrst_ovf",   overflow,  0);
    got.delete();
    rmode = 1;
    send(8, 32'h5A);
    idle(10);
    chk("mrst_count", got.size(), 1);
    chk("mrst_byte",  {19'd0, at(0)},
        {19'd0, huff_byte_t'{8'h5A, 1'b1, 4'd8}});

    // Random bursts, random gaps, random sink stalls
    do_reset();
    exp_q.delete();
    rmode = 2;
    for (int n = 0; n < 200; n++) begin
      int          len;
      logic [31:0] code;
      len  = $urandom_range(1, 31);
      code = $urandom & ((32'd1 << len) - 1);
      model(len, code);
      send(len, code);
      idle($urandom_range(1, 4));
    end
    rmode = 1;
    idle(40);
    chk_seq("rand");
    chk("rand_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/huff_bit_packer.md
# huff_bit_packer

Downstream stage of the Huffman encoder. It captures the encoder's serial `out_valid`/`out_code` bitstream, one bit per cycle, and packs each contiguous burst into MSB-first bytes. The bytes are buffered in a small FIFO and presented on a valid/ready interface for a byte-wide sink. The final byte of each burst carries a `last` flag and a valid-bit count, so codes of any length (1–31 bits) are framed losslessly.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: byte entries in the output FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  encoder `out_valid`; high for the whole burst, with no gaps inside a burst.
- `in_code`  in  1  encoder `out_code`; the first bit of the burst is the MSB of the code.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  sink accepts the head byte when `out_valid && out_ready`.
- `out_data`  out  8  packed byte, MSB = earliest bit; unused low bits are 0.
- `out_last`  out  1  byte is the final byte of its burst.
- `out_nbits`  out  4  valid bits in `out_data`, 1..8; equals 8 on every non-last byte.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- **Shift register.** `sreg[7:0]` and `cnt[2:0]`.
  - Each cycle with `in_valid=1`: `sreg <= {sreg[6:0], in_code}` and `cnt <= cnt+1`, wrapping at 8.
  - When `cnt` goes 7→0, the completed byte moves to the staging register `stg`, with `stg_full=1` and `stg_n=8`.
- **Staging delays every byte push by one cycle,** so that `last` is known when the byte is written. On a cycle where `stg_full=1`:
  - `in_valid=1`: push `{stg, last=0, nbits=8}`.
  - `in_valid=0`: push `{stg, last=1, nbits=8}`. The burst length was a multiple of 8.
- **End of burst.** The first cycle with `in_valid=0` after a cycle with `in_valid=1` (tracked by `prev_valid`):
  - If `cnt≠0`, push `{sreg<<(8-cnt), last=1, nbits=cnt}`, then clear `cnt` and `sreg`.
  - If `cnt=0`, the staging rule above supplies `last`. The two cases never coincide, so at most one push happens per cycle.
- **FIFO.**
  - First-word-fall-through. Entries are `{data[7:0], last, nbits[3:0]}`.
  - Read and write pointers are `log2(FIFO_DEPTH)+1` bits and wrap modulo `2·FIFO_DEPTH`.
  - Full = MSBs differ and low bits are equal. Empty = pointers equal.
- **Push and pop in the same cycle:** always allowed, including when the FIFO is full.
  - Net occupancy stays the same.
  - No overflow is flagged.
- **Overflow.** A push while full without a pop drops the entry, sets `overflow=1` until `rst`, and leaves the FIFO contents unchanged.
- **Zero-bit bursts do not exist.** A 1-bit burst yields one byte: `{b,7'b0}`, last=1, nbits=1.
- **Back-to-back bursts need at least one `in_valid=0` cycle between them.** That gap cycle performs the flush of the previous burst.
- **Reset.**
  - `rst=1` clears `sreg`, `cnt`, `stg_full`, `prev_valid`, both FIFO pointers, and `overflow`.
  - If `in_valid` is still high after reset is released, the bits that follow start a fresh burst.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_nbits=0`, `overflow=0`.
  - `out_data`, `out_last` and `out_nbits` are forced to 0 whenever `out_valid=0`.
- **Full-byte latency:** the 8th bit is sampled at edge t; the byte enters the FIFO at edge t+1. If the FIFO was empty, `out_valid=1` in the cycle after edge t+1.
- **Final-byte latency:** the last bit is sampled at edge t and `in_valid` is 0 at edge t+1. The push happens at edge t+1, and `out_valid` rises in the cycle after it.
- **Handshake.**
  - `out_valid` never depends combinationally on `out_ready`.
  - The head entry holds stable until it is accepted.
  - Throughput is 1 byte/cycle when `out_ready=1`.
- **Sustained input rate** is 1 bit/cycle, so the FIFO needs only 1/8 drain duty. With `FIFO_DEPTH=4`, 32 bits can be held with `out_ready=0` and nothing is lost.

## Structure
- **Shared package** `huff_pkg`:
  - `BYTE_W=8`
  - `NBITS_W=4`
  - typedef `huff_byte_t` = struct `{data, last, nbits}`. The encoder-side bench reuses it.
- **One sub-module:** `huff_byte_fifo`, parameterized by `FIFO_DEPTH`. It is FWFT with push/pop/full/empty ports and a register array. The packer top holds the shift, staging and flush control.
- Target size is about 200 lines of RTL in total.

## Test plan
- **5-bit burst `10110`, `out_ready=1`:** one byte `0xB0`, last=1, nbits=5. `out_valid` rises 2 edges after the last bit; `overflow=0`.
- **16-bit burst `0xA5C3`:**
  - Bytes `0xA5` (last=0, nbits=8), then `0xC3` (last=1, nbits=8).
  - The second byte is pushed in the first `in_valid=0` cycle.
- **31-bit burst, `out_ready=0` throughout, then released:** 4 bytes are buffered with no overflow. They drain as 8, 8, 8, 7 bits, with last only on the 4th (nbits=7).
- **Two 31-bit bursts separated by 1 idle cycle, `out_ready=0`:** the 5th byte push sets `overflow=1`, and the first 4 bytes are unchanged. Bonus: a push and pop on the same edge while full does not set overflow.
- **Reset mid-burst:** `rst` is pulsed after 3 bits while `in_valid` stays high for 8 more bits. All outputs read 0 in the cycle after reset. Exactly one byte follows, holding the 8 post-reset bits, with last=1.
- **Random `out_ready` (50%) over 200 bursts of random length 1..31 with random gaps of 1..4 cycles:** the scoreboard reconstructs every code bit-exact; `overflow` stays 0.
